// File: rtl/sdam_pkg.sv
// Shared types and constants for the SDAM single-wire write link.
// Used by the frame scheduler and its round-robin arbiter.
package sdam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_START,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } sdam_state_e;

  localparam int SDAM_ADDR_W    = 8;
  localparam int SDAM_DATA_W    = 16;
  localparam int SDAM_FRAME_LEN = 28;

  localparam logic SDAM_BIT_PRE       = 1'b1;
  localparam logic SDAM_BIT_START     = 1'b0;
  localparam logic SDAM_BIT_CMD_WRITE = 1'b1;
  localparam logic SDAM_BIT_STOP      = 1'b1;

  localparam logic [4:0] SDAM_ADDR_LAST = 5'(SDAM_ADDR_W - 1);
  localparam logic [4:0] SDAM_DATA_LAST = 5'(SDAM_DATA_W - 1);

endpackage

// File: rtl/sdam_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the
// last granted requester and wraps around.
module sdam_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  int   k;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + 1 + i) % NUM_REQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/sdam_frame_scheduler.sv
// SDAM master sequencer: arbitrates requesters round-robin and
// serializes the granted addr/data pair as one write frame.
module sdam_frame_scheduler
  import sdam_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*8-1:0]    req_addr,
  input  logic [NUM_REQ*16-1:0]   req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic                    sda_o,
  output logic                    sda_oe
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  sdam_state_e state_q, state_d;

  logic [4:0]             cnt_q, cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [SDAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SDAM_DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       own_q, own_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   sda_o_q, sda_o_d;
  logic                   sda_oe_q, sda_oe_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               grant;

  sdam_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Pointer resets to the last requester so requester 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      own_q    <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      sda_o_q  <= 1'b1;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      sda_o_q  <= sda_o_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_PRE;
          grant   = 1'b1;
          ptr_d   = gnt_idx;
          own_d   = gnt_idx;
          addr_d  = req_addr[int'(gnt_idx)*SDAM_ADDR_W +: SDAM_ADDR_W];
          data_d  = req_data[int'(gnt_idx)*SDAM_DATA_W +: SDAM_DATA_W];
        end
      end
      ST_PRE:   state_d = ST_START;
      ST_START: state_d = ST_CMD;
      ST_CMD: begin
        state_d = ST_ADDR;
        cnt_d   = '0;
      end
      ST_ADDR: begin
        if (cnt_q == SDAM_ADDR_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == SDAM_DATA_LAST) begin
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_STOP: begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so the wire
  // shows each bit during the cycle its state is current.
  always_comb begin
    ack_d    = grant ? gnt : '0;
    done_d   = '0;
    busy_d   = (state_d != ST_IDLE);
    sda_oe_d = 1'b1;
    sda_o_d  = 1'b1;
    if (state_q == ST_STOP) begin
      done_d[own_q] = 1'b1;
    end
    unique case (state_d)
      ST_PRE:   sda_o_d = SDAM_BIT_PRE;
      ST_START: sda_o_d = SDAM_BIT_START;
      ST_CMD:   sda_o_d = SDAM_BIT_CMD_WRITE;
      ST_ADDR:  sda_o_d = addr_d[cnt_d[2:0]];
      ST_DATA:  sda_o_d = data_d[cnt_d[3:0]];
      ST_STOP:  sda_o_d = SDAM_BIT_STOP;
      default: begin
        sda_oe_d = 1'b0;
        sda_o_d  = 1'b1;
      end
    endcase
  end

  assign ack    = ack_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign sda_o  = sda_o_q;
  assign sda_oe = sda_oe_q;

endmodule

// File: tb/tb_sdam_frame_scheduler.sv
// Scoreboard bench for sdam_frame_scheduler with a behavioural
// SDAM receiver on the pulled-up line.
module tb_sdam_frame_scheduler;

  localparam int N   = 2;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req = '0;
  logic [15:0]   req_addr = '0;
  logic [31:0]   req_data = '0;
  logic [N-1:0]  ack;
  logic [N-1:0]  done;
  logic          busy;
  logic          sda_o;
  logic          sda_oe;

  sdam_frame_scheduler #(
    .NUM_REQ    (N),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .done     (done),
    .busy     (busy),
    .sda_o    (sda_o),
    .sda_oe   (sda_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got=timeout want=event (t=%0t)", nm, $time);
  endtask

  typedef struct {
    int          idx;
    logic [7:0]  a;
    logic [15:0] d;
    int          gap;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } rx_t;

  exp_t exp_q[$];
  rx_t  rx_q[$];
  int   pend_idx[$];
  int   pend_cyc[$];

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // PRE, START, CMD, 8 addr bits, 16 data bits, STOP; bit 0 goes first
  function automatic logic [27:0] frame_bits(input logic [7:0] a,
                                             input logic [15:0] d);
    return {1'b1, d, a, 1'b1, 1'b0, 1'b1};
  endfunction

  exp_t        e;
  rx_t         r;
  logic [27:0] cur_bits;
  int          bitpos   = 0;
  bit          active   = 0;
  int          last_ack = 0;
  int          busy_end = -1;
  int          pi, pc;
  logic        line;
  int          rx_st = 0;
  int          rx_n  = 0;
  logic [23:0] rx_sh;
  int          rx_cnt = 0;

  // Monitor: pops expectations whenever the DUT presents a pulse or bit.
  always @(negedge clk) begin
    if (reset) begin
      active   = 0;
      busy_end = -1;
      rx_st    = 0;
      pend_idx.delete();
      pend_cyc.delete();
      rx_q.delete();
    end else begin
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", ack, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_idx", ack, onehot(e.idx));
          if (e.gap > 0) chk("ack_period", cyc - last_ack, e.gap);
          last_ack = cyc;
          cur_bits = frame_bits(e.a, e.d);
          bitpos   = 0;
          active   = 1;
          busy_end = cyc + 27 + GAP;
          pend_idx.push_back(e.idx);
          pend_cyc.push_back(cyc);
          r.a = e.a;
          r.d = e.d;
          rx_q.push_back(r);
        end
      end
      if (active) begin
        chk("frame_oe", sda_oe, 1);
        chk($sformatf("frame_bit%0d", bitpos), sda_o, cur_bits[bitpos]);
        bitpos++;
        if (bitpos == 28) active = 0;
      end else begin
        chk("released", {sda_oe, sda_o}, 2'b01);
      end
      chk("busy", busy, (cyc <= busy_end) ? 1 : 0);
      if (done != '0) begin
        if (pend_idx.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          pi = pend_idx.pop_front();
          pc = pend_cyc.pop_front();
          chk("done_idx", done, onehot(pi));
          chk("ack_to_done", cyc - pc, 28);
        end
      end
      line = sda_oe ? sda_o : 1'b1;
      case (rx_st)
        0: if (!line) rx_st = 1;
        1: begin
          rx_st = line ? 2 : 0;
          rx_n  = 0;
        end
        2: begin
          rx_sh[rx_n] = line;
          rx_n++;
          if (rx_n == 24) rx_st = 3;
        end
        default: begin
          rx_st = 0;
          chk("rx_stop", line, 1);
          rx_cnt++;
          if (rx_q.size() == 0) begin
            chk("rx_unexpected", rx_sh, 0);
          end else begin
            r = rx_q.pop_front();
            chk("rx_aout", rx_sh[7:0], r.a);
            chk("rx_dout", rx_sh[23:8], r.d);
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input int idx, input int a, input int d,
                          input int gap);
    exp_t x;
    x.idx = idx;
    x.a   = 8'(a);
    x.d   = 16'(d);
    x.gap = gap;
    exp_q.push_back(x);
  endtask

  task automatic set_req(input int k, input int a, input int d);
    req_addr[k*8 +: 8]   = 8'(a);
    req_data[k*16 +: 16] = 16'(d);
  endtask

  task automatic wait_ack(input int k, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack[k] && n < budget);
    if (!ack[k]) fail($sformatf("wait_ack%0d", k));
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while (!(busy == 1'b0 && exp_q.size() == 0 && pend_idx.size() == 0)
           && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail("wait_quiet");
    repeat (2) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  int n;
  int rx_base;

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_sda_o", sda_o, 1);
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // 1: single write
    set_req(0, 'h05, 'hA5C3);
    push_exp(0, 'h05, 'hA5C3, 0);
    req[0] = 1'b1;
    wait_ack(0, 4, n);
    chk("same_edge_grant", n, 1);
    req[0] = 1'b0;
    wait_quiet(100);

    // 2: simultaneous requests after reset
    do_reset();
    set_req(0, 'h10, 'h1111);
    set_req(1, 'h20, 'h2222);
    push_exp(0, 'h10, 'h1111, 0);
    push_exp(1, 'h20, 'h2222, 31);
    req = 2'b11;
    wait_ack(0, 4, n);
    req[0] = 1'b0;
    wait_ack(1, 40, n);
    req[1] = 1'b0;
    wait_quiet(100);

    // 3: fairness with both requests held
    set_req(0, 'h3A, 'h1234);
    set_req(1, 'hC5, 'hFEDC);
    for (int i = 0; i < 6; i++) begin
      push_exp(i % 2, (i % 2) ? 'hC5 : 'h3A, (i % 2) ? 'hFEDC : 'h1234,
               (i == 0) ? 0 : 31);
    end
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_ack(i % 2, 40, n);
    end
    req = 2'b00;
    wait_quiet(100);

    // 4: withdrawn request mid-frame
    set_req(0, 'h77, 'h0F0F);
    push_exp(0, 'h77, 'h0F0F, 0);
    req[0] = 1'b1;
    wait_ack(0, 4, n);
    req[0] = 1'b0;
    repeat (5) tick();
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    wait_quiet(100);
    repeat (10) tick();
    chk("withdraw_oe", sda_oe, 0);
    chk("withdraw_busy", busy, 0);

    // 5: reset during DATA bit 5, then pointer back to requester 0
    set_req(0, 'h3C, 'hBEEF);
    push_exp(0, 'h3C, 'hBEEF, 0);
    req[0] = 1'b1;
    wait_ack(0, 4, n);
    req[0] = 1'b0;
    repeat (16) tick();
    chk("pre_reset_oe", sda_oe, 1);
    reset = 1'b1;
    #1;
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_sda_o", sda_o, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ack", ack, 0);
    tick();
    reset = 1'b0;
    tick();
    set_req(0, 'h41, 'h4141);
    set_req(1, 'h42, 'h4242);
    push_exp(0, 'h41, 'h4141, 0);
    push_exp(1, 'h42, 'h4242, 31);
    req = 2'b11;
    wait_ack(0, 4, n);
    req[0] = 1'b0;
    wait_ack(1, 40, n);
    req[1] = 1'b0;
    wait_quiet(100);
    set_req(1, 'h99, 'h5A5A);
    push_exp(1, 'h99, 'h5A5A, 0);
    req[1] = 1'b1;
    wait_ack(1, 4, n);
    req[1] = 1'b0;
    wait_quiet(100);
    set_req(0, 'hE1, 'h0001);
    set_req(1, 'hE2, 'h8000);
    push_exp(0, 'hE1, 'h0001, 0);
    push_exp(1, 'hE2, 'h8000, 31);
    req = 2'b11;
    wait_ack(0, 4, n);
    req[0] = 1'b0;
    wait_ack(1, 40, n);
    req[1] = 1'b0;
    wait_quiet(100);

    // 6: 32-frame loopback through the receiver
    rx_base = rx_cnt;
    for (int i = 0; i < 32; i++) begin
      set_req(i % 2, i, i * 'h0101);
      push_exp(i % 2, i, i * 'h0101, (i == 0) ? 0 : 31);
      req[i % 2] = 1'b1;
      wait_ack(i % 2, 40, n);
      req[i % 2] = 1'b0;
    end
    wait_quiet(100);
    repeat (5) tick();
    chk("rx_frames", rx_cnt - rx_base, 32);
    chk("rx_drained", rx_q.size(), 0);
    chk("exp_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdam_frame_scheduler.md
Name: sdam_frame_scheduler

Overview:
- Master-side sequencer for the SDAM single-wire write link.
- Shares one SDA line between NUM_REQ independent requesters using round-robin arbitration.
- Serializes the granted address/data pair into the SDAM write frame on sda_o/sda_oe.
- Sits upstream of the SDAM receiver. Both run on the same clock, with clk driving SCL.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- GAP_CYCLES, 2, released-bus cycles after each frame before the next arbitration (minimum 1).

Ports:
- clk  in  1  link clock; also drives SCL.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request (level).
- req_addr  in  NUM_REQ*8  packed addresses; requester k uses bits [8k+7:8k].
- req_data  in  NUM_REQ*16  packed data; requester k uses bits [16k+15:16k].
- ack  out  NUM_REQ  one-cycle pulse: requester's addr/data latched.
- done  out  NUM_REQ  one-cycle pulse: requester's frame completed on the wire.
- busy  out  1  high from grant until the end of GAP.
- sda_o  out  1  serial data, registered.
- sda_oe  out  1  SDA drive enable, registered; 0 means released (line pulled up).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: sda_oe=0, sda_o=1, ack=0, done=0, busy=0, FSM=IDLE, round-robin pointer = requester 0 highest priority.
- All outputs are registered and change only on posedge clk, or asynchronously on reset.
- Frame, one bit per cycle, sda_oe=1 throughout:
  - PRE: 1
  - START: 0
  - CMD: 1
  - ADDR: 8 bits, LSB first
  - DATA: 16 bits, LSB first
  - STOP: 1
  - Total: 28 driven cycles.
- FSM states: IDLE -> PRE -> START -> CMD -> ADDR -> DATA -> STOP -> GAP -> IDLE.
  - ADDR and DATA share a 5-bit bit counter, cleared on state entry.
  - ADDR exits after count 7; DATA exits after count 15.
- IDLE and grant:
  - Any req=1 at a posedge selects a winner and latches its addr/data into shadow registers.
  - The FSM enters PRE on that edge; ack[winner]=1 and busy=1 for the PRE cycle.
  - Same-edge grant: no extra idle cycle.
- Arbitration:
  - Search starts at (last_grant+1) mod NUM_REQ.
  - The pointer updates to the winner on grant.
  - Implemented as a combinational priority rotate in the sub-module.
- Request rules:
  - A requester must hold addr/data stable while req=1 and no ack has been seen.
  - Inputs are don't-care after ack; the shadow copy is transmitted.
  - req still high after ack counts as a new request at the next arbitration.
- GAP:
  - Lasts GAP_CYCLES cycles with sda_oe=0 and sda_o=1.
  - done[granted]=1 in the first GAP cycle only.
  - busy drops on return to IDLE.
  - Arbitration happens only in IDLE; requests arriving mid-frame wait.
- Latency:
  - ack to done = 28 cycles.
  - Back-to-back frame period = 28 + GAP_CYCLES + 1 cycles. Default: 31.
- req deasserted before ack: the request is withdrawn, with no ack or frame. After ack, req has no effect on the current frame.
- Reset mid-frame:
  - Immediately sda_oe=0, sda_o=1, all pulses cleared.
  - The frame is abandoned with no done; the pointer returns to requester 0.
- ack and done are one-hot or zero, never multi-bit.

Decomposition:
- Package sdam_pkg:
  - State enum.
  - SDAM_ADDR_W=8, SDAM_DATA_W=16.
  - SDAM_FRAME_LEN=28.
  - Bit constants: PRE=1, START=0, CMD_WRITE=1, STOP=1.
- Sub-module sdam_rr_arbiter, parameter NUM_REQ:
  - Inputs: req, pointer.
  - Outputs: one-hot gnt and the encoded index.
- Top-level: FSM, counters and shift registers.

Test Plan:
1. Single write: reset, then req[0]=1, addr=0x05, data=0xA5C3.
   - Required sda_o: 1,0,1, then 1,0,1,0,0,0,0,0, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1; sda_oe=1 for 28 cycles.
   - ack[0] in the PRE cycle; done[0] exactly 28 cycles later.
2. Simultaneous requests: req=2'b11 on the same edge after reset (addr 0x10/0x20).
   - Requester 0 is framed first, then requester 1.
   - Second PRE occurs 31 cycles after the first (GAP=2).
3. Fairness: both req held high continuously for 6 frames.
   - Grant order 0,1,0,1,0,1; each ack is followed by exactly one done to the same index.
4. Withdrawal: req[1] pulsed for 1 cycle during a frame to requester 0.
   - No ack[1] and no second frame; bus stays released (sda_oe=0) after GAP.
5. Reset mid-frame: assert reset during DATA bit 5.
   - Same cycle: sda_oe=0, sda_o=1, busy=0, no done.
   - After release, req[1]-only framed normally; then req=2'b11 grants 0 first.
6. Loopback: drive sda_o/sda_oe into an SDAM receiver (SDA pullup, SCL=clk) for 32 frames, addr i, data i*0x0101.
   - Receiver reports avalid&dvalid with aout=i, dout=i*0x0101 for every i.
